sigma_bus_arb2: RTL and testbench
=================================

SIGMA_BUS_ARB2 -- requirements
Module: sigma_bus_arb2

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; clock port clk_i, reset port arst_i.
REQ-002 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; RR, default 1, 1 = round-robin, 0 = fixed priority with m0 highest.
REQ-003 clk_i  input  1  system clock; all state changes on the rising edge.
REQ-004 arst_i  input  1  asynchronous active-high reset.
REQ-005 mN_req_i, N=0,1  input  1  master N request; held until mN_ack_o.
REQ-006 mN_we_i  input  1  master N write enable (1 = write, 0 = read).
REQ-007 mN_addr_i  input  ADDR_W  master N address.
REQ-008 mN_be_i  input  DATA_W/8  master N byte enables.
REQ-009 mN_wdata_i  input  DATA_W  master N write data.
REQ-010 mN_ack_o  output  1  master N request accepted.
REQ-011 mN_resp_o  output  1  master N read data valid, one-cycle pulse.
REQ-012 mN_rdata_o  output  DATA_W  master N read data, valid with mN_resp_o.
REQ-013 s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  output  1/1/ADDR_W/DATA_W/8/DATA_W  request to shared slave.
REQ-014 s_ack_i, s_resp_i, s_rdata_i  input  1/1/DATA_W  slave accept, read response, read data.

Function
REQ-015 FSM states SHALL be IDLE, FWD, RDWAIT; at most one transaction outstanding on the slave.
REQ-016 IDLE: if any mN_req_i = 1, winner SHALL be latched into owner register and state SHALL go to FWD next cycle; s_req_o = 0 in IDLE (one-cycle arbitration latency).
REQ-017 Both requests in IDLE, RR=1: winner SHALL be the master not recorded in last_grant; RR=0: winner SHALL be m0.
REQ-018 last_grant SHALL update to owner on entry to FWD.
REQ-019 FWD: s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o SHALL combinationally mirror the owner's inputs; non-owner's request SHALL be ignored.
REQ-020 FWD: mOwner_ack_o SHALL equal s_ack_i; non-owner ack SHALL be 0.
REQ-021 FWD with s_ack_i = 1 and write: next state IDLE.
REQ-022 FWD with s_ack_i = 1 and read: next state RDWAIT, unless s_resp_i = 1 in the same cycle, in which case response SHALL be forwarded that cycle and next state IDLE.
REQ-023 RDWAIT: s_req_o = 0; on s_resp_i = 1, mOwner_resp_o = 1 and mOwner_rdata_o = s_rdata_i that cycle, next state IDLE.
REQ-024 FWD with owner's req_i dropped before ack (protocol violation): s_req_o SHALL follow it to 0 and state SHALL return to IDLE next cycle; no ack issued.
REQ-025 s_resp_i outside RDWAIT/REQ-022 SHALL be discarded; no mN_resp_o pulse.
REQ-026 Non-owner mN_resp_o SHALL be 0 always; mN_rdata_o MAY mirror s_rdata_i for both masters.
REQ-027 Back-to-back: a master returning to IDLE with pending requests SHALL be re-arbitrated the cycle after IDLE is entered; minimum 2 cycles between slave requests.

Reset
REQ-028 arst_i = 1 SHALL immediately force state IDLE, owner = 0, last_grant = 1 (m0 wins first RR tie).
REQ-029 During and after reset, until a new grant: all mN_ack_o, mN_resp_o, s_req_o SHALL be 0; s_we_o, s_addr_o, s_be_o, s_wdata_o SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon it; any late s_ack_i/s_resp_i after reset SHALL be discarded per REQ-025.

Verification
REQ-031 m0 write addr 0x100, wdata 0xDEADBEEF, be 0xF, slave acks 2 cycles after s_req_o -> s_req_o rises 1 cycle after m0_req_i, m0_ack_o pulses with s_ack_i, m1 outputs stay 0.
REQ-032 RR=1, m0 and m1 both reading continuously, slave ack+resp same cycle -> grants alternate m0, m1, m0, m1; each mN_resp_o carries the slave rdata of its own access.
REQ-033 RR=0, both requesting continuously -> m1 never granted while m0_req_i stays 1.
REQ-034 m1 read, slave acks, resp 3 cycles later with 0x12345678 -> state RDWAIT for 3 cycles, s_req_o = 0, m0 request pending meanwhile not forwarded; m1_resp_o = 1, m1_rdata_o = 0x12345678; m0 granted afterwards.
REQ-035 arst_i pulsed while in RDWAIT, then s_resp_i = 1 -> no mN_resp_o; first RR tie after reset granted to m0.
REQ-036 m0 drops req in FWD before ack -> no m0_ack_o, s_req_o falls same cycle, state IDLE next cycle.

Source files
------------

// File: rtl/sigma_bus_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : sigma_bus_arb2
//  Purpose  : Two-master arbiter in front of a single shared slave. One
//             transaction outstanding at a time; round-robin or fixed
//             priority (m0 highest) selected by RR.
//  Revision : 1.0 - initial release
// ============================================================================
module sigma_bus_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic                clk_i,
    input  logic                arst_i,
    // master 0
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    // master 1
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    // shared slave
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FWD    = 2'd1;
    localparam logic [1:0] c_RDWAIT = 2'd2;
    localparam logic       c_RR_EN  = (RR != 0);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_owner;        // 0 = m0, 1 = m1
    logic                r_last_grant;   // master granted most recently
    logic                w_any_req;
    logic                w_winner;
    logic                w_fwd;
    logic                w_resp;
    logic                w_own_req;
    logic                w_own_we;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W/8-1:0] w_own_be;
    logic [DATA_W-1:0]   w_own_wdata;

    // Owner's request fields; the non-owner is never looked at outside IDLE.
    always_comb begin
        w_own_req   = r_owner ? m1_req_i   : m0_req_i;
        w_own_we    = r_owner ? m1_we_i    : m0_we_i;
        w_own_addr  = r_owner ? m1_addr_i  : m0_addr_i;
        w_own_be    = r_owner ? m1_be_i    : m0_be_i;
        w_own_wdata = r_owner ? m1_wdata_i : m0_wdata_i;
    end

    // Arbitration: a tie goes to the master not granted last (RR) or to m0.
    always_comb begin
        w_any_req = m0_req_i | m1_req_i;
        if (m0_req_i && m1_req_i) begin
            w_winner = c_RR_EN ? ~r_last_grant : 1'b0;
        end else begin
            w_winner = m1_req_i;
        end
    end

    // Next-state logic; w_resp marks the cycle a read response is forwarded.
    always_comb begin
        w_state_nxt = r_state;
        w_resp      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = c_FWD;
                end
            end
            c_FWD: begin
                if (!w_own_req) begin
                    // owner withdrew before the slave accepted: abandon
                    w_state_nxt = c_IDLE;
                end else if (s_ack_i) begin
                    if (w_own_we) begin
                        w_state_nxt = c_IDLE;
                    end else if (s_resp_i) begin
                        w_resp      = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_RDWAIT;
                    end
                end
            end
            c_RDWAIT: begin
                if (s_resp_i) begin
                    w_resp      = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State, owner and last-grant registers; last_grant follows owner on FWD entry.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_IDLE) && w_any_req) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    // Slave-side mirror of the owner while forwarding, zero otherwise.
    always_comb begin
        w_fwd     = (r_state == c_FWD);
        s_req_o   = w_fwd & w_own_req;
        s_we_o    = w_fwd ? w_own_we    : 1'b0;
        s_addr_o  = w_fwd ? w_own_addr  : '0;
        s_be_o    = w_fwd ? w_own_be    : '0;
        s_wdata_o = w_fwd ? w_own_wdata : '0;
    end

    // Master-side ack/response steering; read data is shared by both masters.
    always_comb begin
        m0_ack_o   = s_req_o & s_ack_i & ~r_owner;
        m1_ack_o   = s_req_o & s_ack_i &  r_owner;
        m0_resp_o  = w_resp & ~r_owner;
        m1_resp_o  = w_resp &  r_owner;
        m0_rdata_o = s_rdata_i;
        m1_rdata_o = s_rdata_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_sigma_bus_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigma_bus_arb2
//  Purpose  : Self-checking bench for sigma_bus_arb2 (round-robin and
//             fixed-priority instances driven with the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_bus_arb2;

    localparam logic [31:0] c_M0_ADDR  = 32'h0000_0100;
    localparam logic [31:0] c_M1_ADDR  = 32'h0000_0200;
    localparam logic [31:0] c_M0_WDATA = 32'hDEAD_BEEF;
    localparam logic [31:0] c_M1_WDATA = 32'hCAFE_F00D;
    localparam logic [3:0]  c_M0_BE    = 4'hF;
    localparam logic [3:0]  c_M1_BE    = 4'h3;

    logic        clk, arst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_be, m1_be;
    logic        s_ack, s_resp;

    // round-robin instance outputs
    logic        m0_ack, m0_resp, m1_ack, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    // fixed-priority instance outputs
    logic        fp_m0_ack, fp_m0_resp, fp_m1_ack, fp_m1_resp;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_s_req, fp_s_we;
    logic [31:0] fp_s_addr, fp_s_wdata;
    logic [3:0]  fp_s_be;

    int n_cmp = 0;
    int n_err = 0;

    sigma_bus_arb2 #(.ADDR_W(32), .DATA_W(32), .RR(1)) dut_rr (
        .clk_i(clk), .arst_i(arst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata)
    );

    sigma_bus_arb2 #(.ADDR_W(32), .DATA_W(32), .RR(0)) dut_fp (
        .clk_i(clk), .arst_i(arst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_ack_o(fp_m0_ack), .m0_resp_o(fp_m0_resp), .m0_rdata_o(fp_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_ack_o(fp_m1_ack), .m1_resp_o(fp_m1_resp), .m1_rdata_o(fp_m1_rdata),
        .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_addr_o(fp_s_addr), .s_be_o(fp_s_be), .s_wdata_o(fp_s_wdata),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        m0r, m0w, m1r, m1w, sack, sresp;
        logic [31:0] rdata;
        logic        esreq;
        logic [1:0]  src;      // 0 = slave bus idle (zeros), 1 = m0 mirrored, 2 = m1 mirrored
        logic        ea0, ea1, er0, er1;
    } vec_t;

    vec_t vt [0:23];

    function automatic vec_t mk(input logic m0r, m0w, m1r, m1w, sack, sresp,
                                input logic [31:0] rdata, input logic esreq,
                                input logic [1:0] src, input logic ea0, ea1, er0, er1);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
        v.sack = sack; v.sresp = sresp; v.rdata = rdata;
        v.esreq = esreq; v.src = src;
        v.ea0 = ea0; v.ea1 = ea1; v.er0 = er0; v.er1 = er1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m0r, m0w, m1r, m1w, sack, sresp, input logic [31:0] rdata);
        m0_req = m0r; m0_we = m0w; m1_req = m1r; m1_we = m1w;
        s_ack = sack; s_resp = sresp; s_rdata = rdata;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, " s_req"},   {31'd0, s_req},   32'd0);
        chk({tag, " s_we"},    {31'd0, s_we},    32'd0);
        chk({tag, " s_addr"},  s_addr,           32'd0);
        chk({tag, " s_be"},    {28'd0, s_be},    32'd0);
        chk({tag, " s_wdata"}, s_wdata,          32'd0);
        chk({tag, " acks"},    {30'd0, m0_ack, m1_ack},   32'd0);
        chk({tag, " resps"},   {30'd0, m0_resp, m1_resp}, 32'd0);
    endtask

    initial begin
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        string       t;

        m0_addr = c_M0_ADDR;   m1_addr = c_M1_ADDR;
        m0_wdata = c_M0_WDATA; m1_wdata = c_M1_WDATA;
        m0_be = c_M0_BE;       m1_be = c_M1_BE;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        //            m0r m0w m1r m1w ack rsp rdata          sreq src a0 a1 r0 r1
        vt[0]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // m0 write arbitrates
        vt[1]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0); // forwarded
        vt[2]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0);
        vt[3]  = mk(1, 1, 0, 0, 1, 0, 32'h0,          1, 1, 1, 0, 0, 0); // ack 2 cycles later
        vt[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
        vt[5]  = mk(0, 0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // m1 read arbitrates
        vt[6]  = mk(1, 0, 1, 0, 1, 0, 32'h0,          1, 2, 0, 1, 0, 0); // ack, no resp; m0 pending
        vt[7]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // RDWAIT 1
        vt[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // RDWAIT 2
        vt[9]  = mk(1, 0, 0, 0, 0, 1, 32'h12345678,   0, 0, 0, 0, 0, 1); // RDWAIT 3: resp
        vt[10] = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // m0 granted next
        vt[11] = mk(1, 0, 1, 0, 1, 1, 32'hA0A0A0A0,   1, 1, 1, 0, 1, 0); // RR alternation
        vt[12] = mk(1, 0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
        vt[13] = mk(1, 0, 1, 0, 1, 1, 32'hB1B1B1B1,   1, 2, 0, 1, 0, 1);
        vt[14] = mk(1, 0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
        vt[15] = mk(1, 0, 1, 0, 1, 1, 32'hC2C2C2C2,   1, 1, 1, 0, 1, 0);
        vt[16] = mk(1, 0, 1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);
        vt[17] = mk(1, 0, 1, 0, 1, 1, 32'hD3D3D3D3,   1, 2, 0, 1, 0, 1);
        vt[18] = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // m0 granted (last = m1)
        vt[19] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 1, 0, 0, 0, 0); // m0 drops in FWD
        vt[20] = mk(0, 0, 1, 1, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0); // back in IDLE
        vt[21] = mk(0, 0, 1, 1, 0, 1, 32'h55555555,   1, 2, 0, 0, 0, 0); // stray resp discarded
        vt[22] = mk(0, 0, 1, 1, 1, 0, 32'h0,          1, 2, 0, 1, 0, 0); // m1 write acked
        vt[23] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0);

        // reset state, with requests and slave handshakes already asserted
        arst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        #1;
        chk_idle_bus("reset");
        @(negedge clk);
        arst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // table-driven vectors, one per clock
        for (int i = 0; i < 24; i++) begin
            drive(vt[i].m0r, vt[i].m0w, vt[i].m1r, vt[i].m1w, vt[i].sack, vt[i].sresp, vt[i].rdata);
            #1;
            case (vt[i].src)
                2'd1:    begin e_we = vt[i].m0w; e_addr = c_M0_ADDR; e_be = c_M0_BE; e_wdata = c_M0_WDATA; end
                2'd2:    begin e_we = vt[i].m1w; e_addr = c_M1_ADDR; e_be = c_M1_BE; e_wdata = c_M1_WDATA; end
                default: begin e_we = 1'b0;      e_addr = 32'd0;     e_be = 4'd0;    e_wdata = 32'd0;      end
            endcase
            t = $sformatf("v%0d", i);
            chk({t, " s_req"},   {31'd0, s_req},   {31'd0, vt[i].esreq});
            chk({t, " s_we"},    {31'd0, s_we},    {31'd0, e_we});
            chk({t, " s_addr"},  s_addr,           e_addr);
            chk({t, " s_be"},    {28'd0, s_be},    {28'd0, e_be});
            chk({t, " s_wdata"}, s_wdata,          e_wdata);
            chk({t, " m0_ack"},  {31'd0, m0_ack},  {31'd0, vt[i].ea0});
            chk({t, " m1_ack"},  {31'd0, m1_ack},  {31'd0, vt[i].ea1});
            chk({t, " m0_resp"}, {31'd0, m0_resp}, {31'd0, vt[i].er0});
            chk({t, " m1_resp"}, {31'd0, m1_resp}, {31'd0, vt[i].er1});
            if (vt[i].er0) chk({t, " m0_rdata"}, m0_rdata, vt[i].rdata);
            if (vt[i].er1) chk({t, " m1_rdata"}, m1_rdata, vt[i].rdata);
            @(negedge clk);
        end

        // reset during RDWAIT: late response discarded, RR pointer back to m0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);   // m0 read wins (last := m0)
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("rst_rd ack", {31'd0, m0_ack}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);   // now in RDWAIT
        #2 arst = 1'b1;
        #1;
        chk_idle_bus("rst_rd async");
        @(negedge clk);
        arst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
        #1;
        chk("rst_rd late resp", {30'd0, m0_resp, m1_resp}, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);   // tie
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("rst_rd tie addr", s_addr, c_M0_ADDR);
        chk("rst_rd tie acks", {30'd0, m0_ack, m1_ack}, 32'd2);
        @(negedge clk);

        // fixed priority: m1 starved while m0 keeps requesting
        arst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D);
        for (int k = 0; k < 8; k++) begin
            #1;
            t = $sformatf("fp%0d", k);
            chk({t, " m0_ack"},  {31'd0, fp_m0_ack},  {31'd0, k[0]});
            chk({t, " m1_ack"},  {31'd0, fp_m1_ack},  32'd0);
            chk({t, " m1_resp"}, {31'd0, fp_m1_resp}, 32'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
